// File: rtl/approx_mul_seq_if.sv
// Handshake bus for approx_mul_seq: operand side (in_*, a, b, approx)
// and result side (out_*, prod, err). The operand source and the result
// sink both sit on the master side; the multiplier is the slave.
interface approx_mul_seq_if #(
  parameter int unsigned W = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           approx;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] err;

  modport master (
    output in_valid, a, b, approx, out_ready,
    input  in_ready, out_valid, prod, err
  );

  modport slave (
    input  in_valid, a, b, approx, out_ready,
    output in_ready, out_valid, prod, err
  );
endinterface

// File: rtl/approx_mul_seq.sv
// Sequential radix-2 shift-add unsigned multiplier. The exact product and
// a column-truncated approximation are accumulated side by side, one
// multiplier bit per cycle. Each result carries its absolute error, and
// running error statistics (saturating sum, maximum, count) are updated on
// every output handshake.
module approx_mul_seq #(
  parameter int unsigned      W     = 5,
  parameter int unsigned      T     = 3,
  parameter logic [2*W-1:0]   COMP  = '0,
  parameter int unsigned      ACC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  approx_mul_seq_if.slave   bus,
  input  logic              stat_clear,
  output logic [ACC_W-1:0]  err_sum,
  output logic [2*W-1:0]    err_max,
  output logic [ACC_W-1:0]  count
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned IW = $clog2(W);
  // Wide enough to hold err_sum + err without wrapping, whichever is wider
  localparam int unsigned SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  // Bits of a partial product that survive truncation: columns T and up
  function automatic logic [PW-1:0] keep_mask();
    logic [PW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      m[i] = (i >= T);
    end
    return m;
  endfunction

  localparam logic [PW-1:0] KEEP = keep_mask();

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            apx_q;
  logic [IW-1:0]   idx_q;
  logic [PW-1:0]   exact_acc;
  logic [PW-1:0]   trunc_acc;
  logic [PW-1:0]   prod_q;
  logic [PW-1:0]   err_q;

  logic            last;
  logic            hs;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   exact_next;
  logic [PW-1:0]   trunc_next;
  logic [PW:0]     comp_sum;
  logic [PW-1:0]   sel_prod;
  logic [PW-1:0]   abs_err;

  logic [SW-1:0]   sum_base;
  logic [SW-1:0]   sum_wide;
  logic [ACC_W-1:0] sum_next;
  logic [ACC_W-1:0] cnt_base;
  logic [ACC_W-1:0] cnt_next;
  logic [PW-1:0]   max_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Current partial product, running sums including it, and the result
  // that the final BUSY edge registers
  always_comb begin
    last       = (idx_q == IW'(W - 1));
    pp         = b_q[idx_q] ? (PW'(a_q) << idx_q) : '0;
    exact_next = exact_acc + pp;
    trunc_next = trunc_acc + (pp & KEEP);
    comp_sum   = {1'b0, trunc_next} + {1'b0, COMP};
    if (!apx_q) begin
      sel_prod = exact_next;
    end else if (comp_sum[PW]) begin
      sel_prod = '1;
    end else begin
      sel_prod = comp_sum[PW-1:0];
    end
    // COMP can push the approximation above the exact value
    if (exact_next >= sel_prod) begin
      abs_err = exact_next - sel_prod;
    end else begin
      abs_err = sel_prod - exact_next;
    end
  end

  // Operand capture and one shift-add step per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      apx_q     <= 1'b0;
      idx_q     <= '0;
      exact_acc <= '0;
      trunc_acc <= '0;
      prod_q    <= '0;
      err_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            apx_q     <= bus.approx;
            idx_q     <= '0;
            exact_acc <= '0;
            trunc_acc <= '0;
          end
        end
        BUSY: begin
          exact_acc <= exact_next;
          trunc_acc <= trunc_next;
          idx_q     <= idx_q + IW'(1);
          if (last) begin
            prod_q <= sel_prod;
            err_q  <= abs_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.prod = prod_q;
  assign bus.err  = err_q;
  assign hs       = (state_q == DONE) && bus.out_ready;

  // Statistics candidates; a clear on the handshake edge restarts them
  // from this transaction alone
  always_comb begin
    sum_base = stat_clear ? '0 : SW'(err_sum);
    sum_wide = sum_base + SW'(err_q);
    if (sum_wide > SW'({ACC_W{1'b1}})) begin
      sum_next = '1;
    end else begin
      sum_next = ACC_W'(sum_wide);
    end
    cnt_base = stat_clear ? '0 : count;
    if (cnt_base == '1) begin
      cnt_next = cnt_base;
    end else begin
      cnt_next = cnt_base + ACC_W'(1);
    end
    if (stat_clear || (err_q > err_max)) begin
      max_next = err_q;
    end else begin
      max_next = err_max;
    end
  end

  // Statistics registers: update on handshake, zero on a lone clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum <= '0;
      err_max <= '0;
      count   <= '0;
    end else if (hs) begin
      err_sum <= sum_next;
      err_max <= max_next;
      count   <= cnt_next;
    end else if (stat_clear) begin
      err_sum <= '0;
      err_max <= '0;
      count   <= '0;
    end
  end

endmodule

// File: tb/tb_approx_mul_seq.sv
// Bench for approx_mul_seq. Three instances (T=3, T=0, T=10) share one
// stimulus stream; a column-based reference model predicts every result
// and the statistics, and a negedge monitor compares all instances.
module tb_approx_mul_seq;

  localparam int unsigned W     = 5;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned ACC_W = 16;
  localparam int          ND    = 3;
  localparam int unsigned SAT   = (1 << ACC_W) - 1;
  localparam int unsigned PMAX  = (1 << PW) - 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         approx;
  logic         stat_clear;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mon_en;

  logic             ov     [ND];
  logic             ir     [ND];
  logic [PW-1:0]    prod_d [ND];
  logic [PW-1:0]    err_d  [ND];
  logic [PW-1:0]    max_d  [ND];
  logic [ACC_W-1:0] sum_d  [ND];
  logic [ACC_W-1:0] cnt_d  [ND];

  int unsigned exp_prod [ND];
  int unsigned exp_err  [ND];
  int unsigned e_sum    [ND];
  int unsigned e_max    [ND];
  int unsigned e_cnt    [ND];

  int unsigned checks;
  int unsigned errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    approx_mul_seq_if #(.W(W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.approx    = approx;
    assign bus.out_ready = out_ready;
    assign ov[g]     = bus.out_valid;
    assign ir[g]     = bus.in_ready;
    assign prod_d[g] = bus.prod;
    assign err_d[g]  = bus.err;
    approx_mul_seq #(
      .W(W),
      .T((g == 0) ? 3 : ((g == 1) ? 0 : 10)),
      .COMP('0),
      .ACC_W(ACC_W)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .stat_clear(stat_clear),
      .err_sum(sum_d[g]),
      .err_max(max_d[g]),
      .count(cnt_d[g])
    );
  end

  function automatic int unsigned t_of(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 0 : 10);
  endfunction

  // Sum of all partial-product bits a[i]*b[j] landing in column i+j >= t
  function automatic int unsigned ref_trunc(input int unsigned x, input int unsigned y,
                                            input int unsigned t);
    int unsigned s;
    s = 0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (x[i] && y[j] && ((i + j) >= int'(t))) s += (1 << (i + j));
      end
    end
    return s;
  endfunction

  task automatic chk(input string name, input int d, input int unsigned got,
                     input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d got %0d expected %0d at %0t", name, d, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int d = 0; d < ND; d++) begin
      e_sum[d] = 0;
      e_max[d] = 0;
      e_cnt[d] = 0;
    end
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    zero_model();
  endtask

  // One full transaction; hold = cycles out_ready stays low in DONE,
  // clr = stat_clear on the handshake edge, lp/le < 0 skip literal checks
  task automatic do_op(input int unsigned ia, input int unsigned ib, input logic iapx,
                       input int unsigned hold, input logic clr, input int lp, input int le);
    int unsigned ex;
    int unsigned tr;
    int unsigned pr;
    a        = W'(ia);
    b        = W'(ib);
    approx   = iapx;
    in_valid = 1'b1;
    for (int d = 0; d < ND; d++) begin
      ex = ia * ib;
      tr = ref_trunc(ia, ib, t_of(d));
      pr = iapx ? ((tr > PMAX) ? PMAX : tr) : ex;
      exp_prod[d] = pr;
      exp_err[d]  = (ex >= pr) ? ex - pr : pr - ex;
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= int'(W); k++) begin
      tick();
      chk("latency", 0, ov[0], (k == int'(W)) ? 1 : 0);
    end
    for (int n = 0; n < 20 && !ov[0]; n++) tick();
    if (!ov[0]) begin
      chk("done_timeout", 0, ov[0], 1);
      return;
    end
    if (lp >= 0) chk("lit_prod", 0, prod_d[0], lp);
    if (le >= 0) chk("lit_err", 0, err_d[0], le);
    for (int h = 0; h < int'(hold); h++) begin
      in_valid = h[0];
      a        = ~a;
      b        = b + 1'b1;
      chk("hold_in_ready", 0, ir[0], 0);
      chk("hold_out_valid", 0, ov[0], 1);
      tick();
    end
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    stat_clear = clr;
    tick();
    out_ready  = 1'b0;
    stat_clear = 1'b0;
    for (int d = 0; d < ND; d++) begin
      if (clr) begin
        e_sum[d] = 0;
        e_max[d] = 0;
        e_cnt[d] = 0;
      end
      e_sum[d] = (e_sum[d] + exp_err[d] > SAT) ? SAT : e_sum[d] + exp_err[d];
      if (exp_err[d] > e_max[d]) e_max[d] = exp_err[d];
      if (e_cnt[d] < SAT) e_cnt[d]++;
    end
    chk("post_in_ready", 0, ir[0], 1);
    chk("post_out_valid", 0, ov[0], 0);
  endtask

  // Monitor: results whenever out_valid, statistics every cycle
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int d = 0; d < ND; d++) begin
        if (ov[d]) begin
          chk("prod", d, prod_d[d], exp_prod[d]);
          chk("err", d, err_d[d], exp_err[d]);
        end
        chk("err_sum", d, sum_d[d], e_sum[d]);
        chk("err_max", d, max_d[d], e_max[d]);
        chk("count", d, cnt_d[d], e_cnt[d]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks     = 0;
    errors     = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    approx     = 1'b0;
    stat_clear = 1'b0;
    a          = '0;
    b          = '0;
    zero_model();
    for (int d = 0; d < ND; d++) begin
      exp_prod[d] = 0;
      exp_err[d]  = 0;
    end
    #12;
    for (int d = 0; d < ND; d++) begin
      chk("rst_in_ready", d, ir[d], 1);
      chk("rst_out_valid", d, ov[d], 0);
      chk("rst_prod", d, prod_d[d], 0);
      chk("rst_err", d, err_d[d], 0);
      chk("rst_err_sum", d, sum_d[d], 0);
      chk("rst_err_max", d, max_d[d], 0);
      chk("rst_count", d, cnt_d[d], 0);
    end
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Exact 31*31
    do_op(31, 31, 1'b0, 0, 1'b0, 961, 0);

    // Approximate pair and their statistics
    clear_stats();
    do_op(31, 31, 1'b1, 0, 1'b0, 944, 17);
    do_op(5, 3, 1'b1, 0, 1'b0, 8, 7);
    chk("lit_sum2", 0, sum_d[0], 24);
    chk("lit_max2", 0, max_d[0], 17);
    chk("lit_cnt2", 0, cnt_d[0], 2);

    // Back-pressure: 10 held cycles with in_valid pulses
    do_op(19, 23, 1'b1, 10, 1'b0, -1, -1);
    chk("lit_cnt_hold", 0, cnt_d[0], 3);

    // Clear coinciding with handshake, then a lone clear
    do_op(31, 31, 1'b1, 0, 1'b1, 944, 17);
    chk("lit_sum_clr", 0, sum_d[0], 17);
    chk("lit_max_clr", 0, max_d[0], 17);
    chk("lit_cnt_clr", 0, cnt_d[0], 1);
    clear_stats();
    chk("lit_sum_zero", 0, sum_d[0], 0);
    chk("lit_max_zero", 0, max_d[0], 0);
    chk("lit_cnt_zero", 0, cnt_d[0], 0);

    // Asynchronous reset while BUSY at idx=2
    a        = 5'd31;
    b        = 5'd31;
    approx   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    zero_model();
    #1;
    chk("abort_out_valid", 0, ov[0], 0);
    chk("abort_in_ready", 0, ir[0], 1);
    chk("abort_err_sum", 0, sum_d[0], 0);
    chk("abort_count", 0, cnt_d[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    do_op(7, 6, 1'b0, 0, 1'b0, 42, 0);

    // Full operand sweeps, exact then approximate
    for (int m = 0; m < 2; m++) begin
      clear_stats();
      for (int unsigned ai = 0; ai < 32; ai++) begin
        for (int unsigned bi = 0; bi < 32; bi++) begin
          do_op(ai, bi, (m == 1), 0, 1'b0, -1, -1);
        end
      end
      for (int d = 0; d < ND; d++) chk("sweep_count", d, cnt_d[d], 1024);
      if (m == 0) begin
        for (int d = 0; d < ND; d++) chk("sweep_exact_max", d, max_d[d], 0);
      end else begin
        chk("sweep_t3_max", 0, max_d[0], 17);
        chk("sweep_t0_max", 1, max_d[1], 0);
        chk("sweep_t10_max", 2, max_d[2], 961);
        chk("sweep_t10_sum", 2, sum_d[2], SAT);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
